// File: rtl/tt_um_hoene_protocol_parity_tx_pkg.sv
// Shared constants and helpers for the LED-chain parity transmitter.
// Frame layout: payload MSB first, then one even-parity bit.
package tt_um_hoene_protocol_parity_tx_pkg;

  localparam int FRAME_BITS = 32;
  localparam int BIT_CNT_W  = 5;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_LEAD  = 2'd1;
  localparam state_t ST_SHIFT = 2'd2;
  localparam state_t ST_TRAIL = 2'd3;

  // Even parity: the bit that makes the XOR of word plus parity equal zero.
  function automatic logic even_parity(input logic [FRAME_BITS-1:0] word);
    return ^word;
  endfunction

endpackage

// File: rtl/tt_um_hoene_protocol_bitclk.sv
// Free-running bit-period divider. Held at zero while clear_i is high so the
// first period after release is always a full one.
module tt_um_hoene_protocol_bitclk #(
  parameter int CLK_DIV = 4
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic clear_i,
  output logic period_start_o,
  output logic period_end_o,
  output logic period_end_next_o
);

  localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLK_DIV - 1);

  logic [CNT_W-1:0] div_q;
  logic [CNT_W-1:0] div_d;

  // Next divider value: park on clear, wrap at the end of a period.
  always_comb begin
    div_d = div_q;
    if (clear_i) begin
      div_d = {CNT_W{1'b0}};
    end else if (div_q == LAST) begin
      div_d = {CNT_W{1'b0}};
    end else begin
      div_d = div_q + CNT_W'(1'b1);
    end
  end

  // Divider register with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      div_q <= {CNT_W{1'b0}};
    end else begin
      div_q <= div_d;
    end
  end

  assign period_start_o    = (div_q == {CNT_W{1'b0}});
  assign period_end_o      = (div_q == LAST);
  // Lets the owner register strobe outputs that line up with div_cnt.
  assign period_end_next_o = (div_d == LAST);

endmodule

// File: rtl/tt_um_hoene_protocol_parity_tx.sv
// Serial LED-chain transmitter: payload MSB first plus even parity, framed by
// out_sync, with a one-cycle out_clk strobe at the end of every bit period.
module tt_um_hoene_protocol_parity_tx
  import tt_um_hoene_protocol_parity_tx_pkg::*;
#(
  parameter int DATA_BITS = 31,
  parameter int CLK_DIV   = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  input  logic                 force_error,
  output logic                 out_data,
  output logic                 out_clk,
  output logic                 out_sync,
  output logic                 busy
);

  localparam logic [BIT_CNT_W-1:0] LAST_BIT = BIT_CNT_W'(DATA_BITS);

  state_t                 state_q, state_d;
  logic [DATA_BITS-1:0]   shreg_q, shreg_d;
  logic                   parity_q, parity_d;
  logic [BIT_CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic                   tx_ready_q, tx_ready_d;
  logic                   out_data_q, out_data_d;
  logic                   out_clk_q, out_clk_d;
  logic                   out_sync_q, out_sync_d;

  logic clear_s;
  logic period_start_s;
  logic period_end_s;
  logic end_next_s;
  logic hs_s;

  assign clear_s = (state_q == ST_IDLE);

  tt_um_hoene_protocol_bitclk #(
    .CLK_DIV (CLK_DIV)
  ) u_bitclk (
    .clk_i             (clk),
    .rst_n_i           (rst_n),
    .clear_i           (clear_s),
    .period_start_o    (period_start_s),
    .period_end_o      (period_end_s),
    .period_end_next_o (end_next_s)
  );

  // In IDLE the divider must be parked at zero so LEAD gets a full period.
  assign hs_s = tx_valid && tx_ready_q && ((state_q != ST_IDLE) || period_start_s);

  // Frame sequencing: LEAD, DATA_BITS payload bits plus parity, optional chaining.
  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    parity_d  = parity_q;
    bit_cnt_d = bit_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (hs_s) begin
          state_d   = ST_LEAD;
          shreg_d   = tx_data;
          parity_d  = even_parity(FRAME_BITS'(tx_data)) ^ force_error;
          bit_cnt_d = {BIT_CNT_W{1'b0}};
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_LEAD: begin
        if (period_end_s) begin
          state_d   = ST_SHIFT;
          bit_cnt_d = {BIT_CNT_W{1'b0}};
        end else begin
          state_d = ST_LEAD;
        end
      end
      ST_SHIFT: begin
        if (period_end_s && (bit_cnt_q == LAST_BIT)) begin
          if (hs_s) begin
            state_d   = ST_SHIFT;
            shreg_d   = tx_data;
            parity_d  = even_parity(FRAME_BITS'(tx_data)) ^ force_error;
            bit_cnt_d = {BIT_CNT_W{1'b0}};
          end else begin
            state_d = ST_TRAIL;
          end
        end else if (period_end_s) begin
          shreg_d   = shreg_q << 1;
          bit_cnt_d = bit_cnt_q + 5'd1;
        end else begin
          state_d = ST_SHIFT;
        end
      end
      ST_TRAIL: begin
        if (period_end_s) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_TRAIL;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Output values for the next cycle, decoded from next state and divider.
  always_comb begin
    out_sync_d = (state_d != ST_IDLE);
    out_clk_d  = (state_d == ST_SHIFT) && end_next_s;
    if (state_d == ST_SHIFT) begin
      out_data_d = (bit_cnt_d == LAST_BIT) ? parity_d : shreg_d[DATA_BITS-1];
    end else begin
      out_data_d = 1'b0;
    end
    tx_ready_d = (state_d == ST_IDLE) || (out_clk_d && (bit_cnt_d == LAST_BIT));
  end

  // State and registered outputs; reset aborts any frame in progress.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      shreg_q    <= {DATA_BITS{1'b0}};
      parity_q   <= 1'b0;
      bit_cnt_q  <= {BIT_CNT_W{1'b0}};
      tx_ready_q <= 1'b0;
      out_data_q <= 1'b0;
      out_clk_q  <= 1'b0;
      out_sync_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      shreg_q    <= shreg_d;
      parity_q   <= parity_d;
      bit_cnt_q  <= bit_cnt_d;
      tx_ready_q <= tx_ready_d;
      out_data_q <= out_data_d;
      out_clk_q  <= out_clk_d;
      out_sync_q <= out_sync_d;
    end
  end

  assign tx_ready = tx_ready_q;
  assign out_data = out_data_q;
  assign out_clk  = out_clk_q;
  assign out_sync = out_sync_q;
  assign busy     = out_sync_q;

endmodule

// File: tb/tb_tt_um_hoene_protocol_parity_tx.sv
// Directed bench: default instance (31 data bits, divide by 4) plus a small
// instance (7 data bits, divide by 2), with a running-XOR frame checker model.
module tb_tt_um_hoene_protocol_parity_tx;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_pass = 0;

  logic [30:0] a_data = 31'h0;
  logic a_valid = 1'b0, a_fe = 1'b0;
  logic a_ready, a_od, a_oc, a_os, a_busy;
  logic [6:0] b_data = 7'h0;
  logic b_valid = 1'b0, b_fe = 1'b0;
  logic b_ready, b_od, b_oc, b_os, b_busy;

  tt_um_hoene_protocol_parity_tx u_dut_a (
    .clk(clk), .rst_n(rst_n), .tx_data(a_data), .tx_valid(a_valid),
    .tx_ready(a_ready), .force_error(a_fe), .out_data(a_od),
    .out_clk(a_oc), .out_sync(a_os), .busy(a_busy)
  );

  tt_um_hoene_protocol_parity_tx #(.DATA_BITS(7), .CLK_DIV(2)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .tx_data(b_data), .tx_valid(b_valid),
    .tx_ready(b_ready), .force_error(b_fe), .out_data(b_od),
    .out_clk(b_oc), .out_sync(b_os), .busy(b_busy)
  );

  // Monitor for instance A: strobe log, sync drops, ready legality, XOR checker.
  logic a_bits[$];
  int   a_scyc[$];
  int   a_drops = 0, a_drop_cyc = 0, a_rbad = 0, a_sbad = 0, a_err_at = -1, a_n = 0;
  logic a_acc = 1'b0, a_err = 1'b0, a_os_prev = 1'b0;
  always @(negedge clk) begin
    if (a_ready && a_busy && !(a_oc && ((a_n % 32) == 31))) a_rbad++;
    if (a_oc) begin
      a_bits.push_back(a_od);
      a_scyc.push_back(cyc);
      if (!a_os || !a_busy) a_sbad++;
    end
    if (a_os_prev && !a_os) begin
      a_drops++;
      a_drop_cyc = cyc;
    end
    if (!a_os) begin
      a_acc = 1'b0; a_n = 0; a_err = 1'b0;
    end else if (a_oc) begin
      if ((a_n != 0) && ((a_n % 32) == 0) && a_acc && !a_err) begin
        a_err = 1'b1;
        a_err_at = a_n;
      end
      a_acc = a_acc ^ a_od;
      a_n++;
    end
    a_os_prev = a_os;
  end

  // Monitor for instance B.
  logic b_bits[$];
  int   b_scyc[$];
  int   b_drops = 0, b_rbad = 0, b_n = 0;
  logic b_os_prev = 1'b0;
  always @(negedge clk) begin
    if (b_ready && b_busy && !(b_oc && ((b_n % 8) == 7))) b_rbad++;
    if (b_oc) begin
      b_bits.push_back(b_od);
      b_scyc.push_back(cyc);
    end
    if (b_os_prev && !b_os) b_drops++;
    if (!b_os) b_n = 0;
    else if (b_oc) b_n++;
    b_os_prev = b_os;
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    else n_pass++;
  endtask

  task automatic nedge();
    @(negedge clk);
    #1;
  endtask

  task automatic push_a(input logic [30:0] d, input logic fe, input logic keep, output int t);
    int n;
    n = 0;
    a_data = d; a_fe = fe; a_valid = 1'b1;
    while (!a_ready && (n < 400)) begin nedge(); n++; end
    if (n >= 400) check_eq("push_a_timeout", n, 0);
    t = cyc + 1;
    nedge();
    if (!keep) a_valid = 1'b0;
  endtask

  task automatic push_b(input logic [6:0] d, output int t);
    int n;
    n = 0;
    b_data = d; b_fe = 1'b0; b_valid = 1'b1;
    while (!b_ready && (n < 400)) begin nedge(); n++; end
    if (n >= 400) check_eq("push_b_timeout", n, 0);
    t = cyc + 1;
    nedge();
    b_valid = 1'b0;
  endtask

  task automatic wait_drop_a(input string tag);
    int d0, n;
    d0 = a_drops; n = 0;
    while ((a_drops == d0) && (n < 1000)) begin nedge(); n++; end
    if (n >= 1000) check_eq({tag, "_drop_timeout"}, n, 0);
    nedge();
  endtask

  task automatic clear_a();
    a_bits.delete(); a_scyc.delete();
    a_rbad = 0; a_sbad = 0; a_err_at = -1;
  endtask

  task automatic spacing_a(output int mn, output int mx);
    mn = 100000; mx = 0;
    for (int i = 1; i < a_scyc.size(); i++) begin
      if (a_scyc[i] - a_scyc[i-1] < mn) mn = a_scyc[i] - a_scyc[i-1];
      if (a_scyc[i] - a_scyc[i-1] > mx) mx = a_scyc[i] - a_scyc[i-1];
    end
  endtask

  // One 32-bit frame starting at queue index base: payload MSB first, then parity.
  task automatic check_frame_a(input string tag, input int base, input logic [30:0] d,
                               input logic p, input logic x_exp);
    logic [30:0] v;
    logic x, pb, bt;
    v = 31'h0; x = 1'b0; pb = 1'bx;
    for (int i = 0; i < 32; i++) begin
      bt = (base + i < a_bits.size()) ? a_bits[base + i] : 1'bx;
      if (i < 31) v = {v[29:0], bt};
      else pb = bt;
      x = x ^ bt;
    end
    check_eq({tag, "_data"}, {1'b0, v}, {1'b0, d});
    check_eq({tag, "_parity"}, {31'h0, pb}, {31'h0, p});
    check_eq({tag, "_xor"}, {31'h0, x}, {31'h0, x_exp});
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not reach the end");
    $fatal(1);
  end

  initial begin
    int t, t0, t1, t2, mn, mx, d0, n, first;
    logic [6:0] vb;

    // Reset state
    repeat (3) nedge();
    check_eq("rst_ready", a_ready, 0);
    check_eq("rst_sync", a_os, 0);
    check_eq("rst_clk", a_oc, 0);
    check_eq("rst_busy", a_busy, 0);
    check_eq("rst_data", a_od, 0);
    rst_n = 1'b1;
    nedge();
    check_eq("ready_after_rst_a", a_ready, 1);
    check_eq("ready_after_rst_b", b_ready, 1);

    // Single word 0x1: first strobe in cycle T+8 (sampled after edge T+7),
    // out_sync low from cycle T+137 (after edge T+136).
    clear_a();
    push_a(31'h0000_0001, 1'b0, 1'b0, t);
    wait_drop_a("w1");
    check_eq("w1_strobes", a_bits.size(), 32);
    first = (a_scyc.size() > 0) ? a_scyc[0] - t : -1;
    check_eq("w1_first_strobe", first, 7);
    check_eq("w1_sync_fall", a_drop_cyc - t, 136);
    check_frame_a("w1", 0, 31'h0000_0001, 1'b1, 1'b0);
    spacing_a(mn, mx);
    check_eq("w1_space_min", mn, 4);
    check_eq("w1_space_max", mx, 4);
    check_eq("w1_ready_legal", a_rbad, 0);
    check_eq("w1_strobe_in_sync", a_sbad, 0);

    clear_a();
    push_a(31'h0000_0003, 1'b0, 1'b0, t);
    wait_drop_a("w3");
    check_eq("w3_strobes", a_bits.size(), 32);
    check_frame_a("w3", 0, 31'h0000_0003, 1'b0, 1'b0);

    clear_a();
    push_a(31'h7FFF_FFFF, 1'b0, 1'b0, t);
    wait_drop_a("wf");
    check_frame_a("wf", 0, 31'h7FFF_FFFF, 1'b1, 1'b0);

    // Three words back to back: one unbroken burst of 96 strobes.
    clear_a();
    d0 = a_drops;
    push_a(31'h1234_5678, 1'b0, 1'b1, t0);
    push_a(31'h7FFF_FFFF, 1'b0, 1'b1, t1);
    push_a(31'h0000_0000, 1'b0, 1'b0, t2);
    wait_drop_a("b2b");
    check_eq("b2b_strobes", a_bits.size(), 96);
    check_eq("b2b_sync_drops", a_drops - d0, 1);
    check_eq("b2b_chk_err", a_err_at, -1);
    spacing_a(mn, mx);
    check_eq("b2b_space_min", mn, 4);
    check_eq("b2b_space_max", mx, 4);
    check_eq("b2b_ready_legal", a_rbad, 0);
    check_frame_a("b2b_f0", 0, 31'h1234_5678, 1'b1, 1'b0);
    check_frame_a("b2b_f1", 32, 31'h7FFF_FFFF, 1'b1, 1'b0);
    check_frame_a("b2b_f2", 64, 31'h0000_0000, 1'b0, 1'b0);

    // Same burst with parity forced wrong on word 1 only.
    clear_a();
    push_a(31'h1234_5678, 1'b0, 1'b1, t0);
    push_a(31'h7FFF_FFFF, 1'b1, 1'b1, t1);
    push_a(31'h0000_0000, 1'b0, 1'b0, t2);
    a_fe = 1'b0;
    wait_drop_a("ferr");
    check_eq("ferr_err_at_strobe", a_err_at, 64);
    check_frame_a("ferr_f1", 32, 31'h7FFF_FFFF, 1'b0, 1'b1);
    check_eq("ferr_recovered", a_err, 0);

    // Reset during strobe 10 aborts the frame at the next edge.
    clear_a();
    push_a(31'h7FFF_FFFF, 1'b0, 1'b0, t);
    n = 0;
    while ((a_bits.size() < 10) && (n < 1000)) begin nedge(); n++; end
    check_eq("rst_mid_at_strobe10", a_oc, 1);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check_eq("rst_mid_sync", a_os, 0);
    check_eq("rst_mid_clk", a_oc, 0);
    check_eq("rst_mid_busy", a_busy, 0);
    nedge();
    nedge();
    rst_n = 1'b1;
    nedge();
    clear_a();
    push_a(31'h0000_0003, 1'b0, 1'b0, t);
    wait_drop_a("post_rst");
    check_eq("post_rst_strobes", a_bits.size(), 32);
    first = (a_scyc.size() > 0) ? a_scyc[0] - t : -1;
    check_eq("post_rst_first_strobe", first, 7);
    check_frame_a("post_rst", 0, 31'h0000_0003, 1'b0, 1'b0);

    // Small instance: 7 data bits, divide by 2; 7'h5B has five ones -> parity 1.
    b_bits.delete(); b_scyc.delete(); b_rbad = 0;
    d0 = b_drops;
    push_b(7'h5B, t);
    n = 0;
    while ((b_drops == d0) && (n < 200)) begin nedge(); n++; end
    if (n >= 200) check_eq("b_drop_timeout", n, 0);
    check_eq("b_strobes", b_bits.size(), 8);
    first = (b_scyc.size() > 0) ? b_scyc[0] - t : -1;
    check_eq("b_first_strobe", first, 3);
    mn = 100000; mx = 0;
    for (int i = 1; i < b_scyc.size(); i++) begin
      if (b_scyc[i] - b_scyc[i-1] < mn) mn = b_scyc[i] - b_scyc[i-1];
      if (b_scyc[i] - b_scyc[i-1] > mx) mx = b_scyc[i] - b_scyc[i-1];
    end
    check_eq("b_space_min", mn, 2);
    check_eq("b_space_max", mx, 2);
    vb = 7'h0;
    for (int i = 0; i < 7; i++) vb = {vb[5:0], (i < b_bits.size()) ? b_bits[i] : 1'bx};
    check_eq("b_data", {25'h0, vb}, 32'h0000_005B);
    check_eq("b_parity", (b_bits.size() > 7) ? {31'h0, b_bits[7]} : 32'hFFFF_FFFF, 1);
    check_eq("b_ready_legal", b_rbad, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
